// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - requester handshake and adder-slice signals for nibble_serial_add_ctrl
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [3:0]       add_x;
    logic [3:0]       add_y;
    logic             add_z;
    logic [3:0]       add_s;
    logic             add_co;

    modport master (
        output start, a, b, cin, add_s, add_co,
        input  ready, done, sum, cout, add_x, add_y, add_z
    );

    modport slave (
        input  start, a, b, cin, add_s, add_co,
        output ready, done, sum, cout, add_x, add_y, add_z
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit a+b+cin computed one nibble per cycle on a shared 4-bit adder slice
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             cout_reg;
    logic             ready_reg;
    logic             done_reg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            cout_reg  <= 1'b0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry     <= bus.cin;
                        cnt       <= '0;
                        sum_reg   <= '0;
                        ready_reg <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Operands shift down so the live nibble is always at [3:0].
                    sum_reg[int'(cnt)*4 +: 4] <= bus.add_s;
                    carry <= bus.add_co;
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_reg <= bus.add_co;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_reg;
    assign bus.done  = done_reg;
    assign bus.sum   = sum_reg;
    assign bus.cout  = cout_reg;
    assign bus.add_x = (state == RUN) ? a_reg[3:0] : 4'd0;
    assign bus.add_y = (state == RUN) ? b_reg[3:0] : 4'd0;
    assign bus.add_z = (state == RUN) ? carry : 1'b0;
endmodule
